prog_counter_n: RTL and testbench

PROG_COUNTER_N -- requirements
Module: prog_counter_n

---
 rtl/prog_counter_n.sv | 74 +++++++
 tb/tb_prog_counter_n.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter_n.sv
// Parameterised up/down program counter with load, synchronous clear and
// wrap or saturate behaviour, plus a registered boundary-crossing pulse.
module prog_counter_n #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned STEP     = 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum, diff;
    logic             count_up, count_down;

    // Extra top bit of sum/diff is the carry/borrow out of the WIDTH-bit count.
    assign sum        = {1'b0, out_q} + STEP_EXT;
    assign diff       = {1'b0, out_q} - STEP_EXT;
    assign count_up   = en & inc & ~dec;
    assign count_down = en & dec & ~inc;

    always_comb begin
        out_d = out_q;
        ovf_d = 1'b0;
        if (clr) begin
            out_d = '0;
        end else if (load) begin
            out_d = in;
        end else if (count_up) begin
            ovf_d = sum[WIDTH];
            if (sum[WIDTH] && SATURATE) begin
                out_d = '1;
            end else begin
                out_d = sum[WIDTH-1:0];
            end
        end else if (count_down) begin
            ovf_d = diff[WIDTH];
            if (diff[WIDTH] && SATURATE) begin
                out_d = '0;
            end else begin
                out_d = diff[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign out    = out_q;
    assign ovf    = ovf_q;
    assign at_max = &out_q;
    assign at_min = ~|out_q;

endmodule

// File: tb/tb_prog_counter_n.sv
// Self-checking bench for prog_counter_n: three configurations driven in
// parallel (wrap STEP=1, saturate STEP=1, wrap STEP=3) against an arithmetic model.
module tb_prog_counter_n;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0, load = 1'b0, en = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [15:0] in = 16'h0000;

    logic [15:0] out_a [3];
    logic        ovf_a [3];
    logic        max_a [3];
    logic        min_a [3];

    // Reference model state per instance
    logic [15:0] m_out [3];
    logic        m_ovf [3];
    int          steps [3] = '{1, 1, 3};
    bit          sats  [3] = '{1'b0, 1'b1, 1'b0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_counter_n #(.WIDTH(16), .STEP(1), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .in(in), .en(en), .inc(inc),
        .dec(dec), .out(out_a[0]), .ovf(ovf_a[0]), .at_max(max_a[0]), .at_min(min_a[0])
    );
    prog_counter_n #(.WIDTH(16), .STEP(1), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .in(in), .en(en), .inc(inc),
        .dec(dec), .out(out_a[1]), .ovf(ovf_a[1]), .at_max(max_a[1]), .at_min(min_a[1])
    );
    prog_counter_n #(.WIDTH(16), .STEP(3), .SATURATE(1'b0)) u_step3 (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .in(in), .en(en), .inc(inc),
        .dec(dec), .out(out_a[2]), .ovf(ovf_a[2]), .at_max(max_a[2]), .at_min(min_a[2])
    );

    // Next {ovf, out} from plain integer arithmetic on the command rules.
    function automatic logic [16:0] model_next(input logic [15:0] cur, input int step,
                                               input bit sat, input logic c, l, e, i, d,
                                               input logic [15:0] v);
        longint s;
        if (c) return 17'h0;
        if (l) return {1'b0, v};
        if (e && i && !d) begin
            s = longint'(cur) + step;
            if (s > 65535) return sat ? {1'b1, 16'hFFFF} : {1'b1, 16'(s - 65536)};
            return {1'b0, 16'(s)};
        end
        if (e && d && !i) begin
            s = longint'(cur) - step;
            if (s < 0) return sat ? {1'b1, 16'h0000} : {1'b1, 16'(s + 65536)};
            return {1'b0, 16'(s)};
        end
        return {1'b0, cur};
    endfunction

    // Drive one command, clock it in, advance the model, settle 1 time unit past the edge.
    task automatic apply(input logic c, l, e, i, d, input logic [15:0] v);
        logic [16:0] nx;
        clr = c; load = l; en = e; inc = i; dec = d; in = v;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_out[k] = 16'h0;
                m_ovf[k] = 1'b0;
            end else begin
                nx = model_next(m_out[k], steps[k], sats[k], c, l, e, i, d, v);
                m_out[k] = nx[15:0];
                m_ovf[k] = nx[16];
            end
        end
        #1;
    endtask

    // Pulse reset between edges; the model loses any state immediately.
    task automatic mid_reset_assert();
        #2 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_out[k] = 16'h0;
            m_ovf[k] = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            m_out[k] = 16'h0;
            m_ovf[k] = 1'b0;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (out_a[0] !== 16'h0 || ovf_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial out=%h ovf=%b expected out=0000 ovf=0", out_a[0], ovf_a[0]);
        end
        for (int n = 0; n < 4; n++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (out_a[k] !== 16'h0 || ovf_a[k] !== 1'b0 || min_a[k] !== 1'b1
                    || max_a[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_hold inst%0d out=%h ovf=%b min=%b max=%b expected 0000/0/1/0",
                             k, out_a[k], ovf_a[k], min_a[k], max_a[k]);
                end
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFE);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if (out_a[0] !== 16'hFFFF || max_a[0] !== 1'b1 || ovf_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_to_max out=%h max=%b ovf=%b expected ffff/1/0",
                     out_a[0], max_a[0], ovf_a[0]);
        end
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if (out_a[0] !== 16'h0000 || ovf_a[0] !== 1'b1 || min_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_over out=%h ovf=%b min=%b expected 0000/1/1",
                     out_a[0], ovf_a[0], min_a[0]);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        checks++;
        if (out_a[0] !== 16'h0000 || ovf_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pulse_end out=%h ovf=%b expected 0000/0", out_a[0], ovf_a[0]);
        end
    endtask

    task automatic test_saturate();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
        for (int n = 0; n < 2; n++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
            checks++;
            if (out_a[1] !== 16'hFFFF || ovf_a[1] !== 1'b1) begin
                errors++;
                $display("FAIL sat_high cyc%0d out=%h ovf=%b expected ffff/1", n, out_a[1], ovf_a[1]);
            end
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0);
        checks++;
        if (out_a[1] !== 16'h0000 || ovf_a[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_low out=%h ovf=%b expected 0000/1", out_a[1], ovf_a[1]);
        end
    endtask

    task automatic test_priority();
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234);
        checks++;
        if (out_a[0] !== 16'h1234 || ovf_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL load_over_inc out=%h ovf=%b expected 1234/0", out_a[0], ovf_a[0]);
        end
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h5555);
        checks++;
        if (out_a[0] !== 16'h0000) begin
            errors++;
            $display("FAIL clr_over_load out=%h expected 0000", out_a[0]);
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00AA);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
        checks++;
        if (out_a[0] !== 16'h00AA || ovf_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL inc_dec_hold out=%h ovf=%b expected 00aa/0", out_a[0], ovf_a[0]);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        checks++;
        if (out_a[0] !== 16'h00AA) begin
            errors++;
            $display("FAIL en_low_hold out=%h expected 00aa", out_a[0]);
        end
    endtask

    task automatic test_step3();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFE);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if (out_a[2] !== 16'h0001 || ovf_a[2] !== 1'b1) begin
            errors++;
            $display("FAIL step3_up out=%h ovf=%b expected 0001/1", out_a[2], ovf_a[2]);
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0);
        checks++;
        if (out_a[2] !== 16'hFFFE || ovf_a[2] !== 1'b1) begin
            errors++;
            $display("FAIL step3_down out=%h ovf=%b expected fffe/1", out_a[2], ovf_a[2]);
        end
    endtask

    task automatic test_mid_reset();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h000F);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if (out_a[0] !== 16'h0010) begin
            errors++;
            $display("FAIL count_to_10 out=%h expected 0010", out_a[0]);
        end
        mid_reset_assert();
        checks++;
        if (out_a[0] !== 16'h0000 || min_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL async_reset out=%h min=%b expected 0000/1", out_a[0], min_a[0]);
        end
        reset = 1'b0;
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if (out_a[0] !== 16'h0001 || ovf_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL after_reset out=%h ovf=%b expected 0001/0", out_a[0], ovf_a[0]);
        end
        // Reset must also kill an ovf pulse already in flight.
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        mid_reset_assert();
        checks++;
        if (ovf_a[0] !== 1'b0 || out_a[0] !== 16'h0000) begin
            errors++;
            $display("FAIL reset_kills_ovf out=%h ovf=%b expected 0000/0", out_a[0], ovf_a[0]);
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic        c, l, e, i, d;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       v = 16'($urandom_range(0, 3));
                1:       v = 16'hFFFF - 16'($urandom_range(0, 3));
                default: v = 16'($urandom);
            endcase
            c = ($urandom_range(0, 29) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 4) != 0);
            i = 1'($urandom);
            d = 1'($urandom);
            apply(c, l, e, i, d, v);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (out_a[k] !== m_out[k] || ovf_a[k] !== m_ovf[k]) begin
                    errors++;
                    $display("FAIL rand_state inst%0d cyc%0d out=%h ovf=%b expected out=%h ovf=%b",
                             k, n, out_a[k], ovf_a[k], m_out[k], m_ovf[k]);
                end
                checks++;
                if (max_a[k] !== (m_out[k] == 16'hFFFF) || min_a[k] !== (m_out[k] == 16'h0)) begin
                    errors++;
                    $display("FAIL rand_flags inst%0d cyc%0d max=%b min=%b for expected out=%h",
                             k, n, max_a[k], min_a[k], m_out[k]);
                end
            end
            if ($urandom_range(0, 39) == 0) begin
                mid_reset_assert();
                checks++;
                if (out_a[0] !== 16'h0 || out_a[1] !== 16'h0 || out_a[2] !== 16'h0
                    || ovf_a[0] !== 1'b0 || ovf_a[1] !== 1'b0 || ovf_a[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_reset cyc%0d out=%h/%h/%h expected 0000 all", n,
                             out_a[0], out_a[1], out_a[2]);
                end
                reset = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_priority();
        test_step3();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
